// File: rtl/boot_loader_if.sv
// Signal bundle between boot_loader, the BIOS ROM, instruction memory and the fetch mux.
// Defining BOOT_CHECKSUM_EN adds the checksum status signals.
interface boot_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] bios_addr;
  logic [DATA_WIDTH-1:0] bios_data;
  logic                  imem_we;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  busy;
  logic                  done;
  logic                  changeSource;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
  logic                  checksum_ok;
`endif

  modport master (
    input  start, bios_data,
    output bios_addr, imem_we, imem_addr, imem_wdata, busy, done, changeSource
`ifdef BOOT_CHECKSUM_EN
    , output checksum, checksum_ok
`endif
  );

  modport slave (
    output start, bios_data,
    input  bios_addr, imem_we, imem_addr, imem_wdata, busy, done, changeSource
`ifdef BOOT_CHECKSUM_EN
    , input checksum, checksum_ok
`endif
  );
endinterface

// File: rtl/boot_loader.sv
// Copies BIOS_WORDS words from the BIOS ROM (1-cycle read latency) into instruction memory,
// then hands fetch over to instruction memory. Optional BOOT_CHECKSUM_EN gates the hand-over on a sum.
module boot_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BIOS_WORDS = 41,
  parameter logic [DATA_WIDTH-1:0] IMEM_BASE  = '0
`ifdef BOOT_CHECKSUM_EN
  , parameter logic [DATA_WIDTH-1:0] EXPECTED_SUM = '0
`endif
) (
  input logic           clock,
  input logic           rst,
  boot_loader_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] L_WORDS = DATA_WIDTH'(BIOS_WORDS);
  localparam logic [DATA_WIDTH-1:0] L_LAST  = DATA_WIDTH'(BIOS_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] L_ONE   = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_rdCnt;
  logic                  r_rdVld;
  logic [DATA_WIDTH-1:0] r_wrCnt;
  logic [DATA_WIDTH-1:0] r_biosAddr;
  logic                  r_imemWe;
  logic [DATA_WIDTH-1:0] r_imemAddr;
  logic [DATA_WIDTH-1:0] r_imemWdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_changeSource;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_checksumOk;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rdCnt        <= '0;
      r_rdVld        <= 1'b0;
      r_wrCnt        <= '0;
      r_biosAddr     <= '0;
      r_imemWe       <= 1'b0;
      r_imemAddr     <= '0;
      r_imemWdata    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_changeSource <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_checksum     <= '0;
      r_checksumOk   <= 1'b0;
`endif
    end else begin
      case (r_state)
        // A start from DONE also drops the hand-over flags; in IDLE they are already clear.
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state        <= S_COPY;
            r_biosAddr     <= '0;
            r_rdCnt        <= L_ONE;
            r_rdVld        <= 1'b0;
            r_wrCnt        <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_changeSource <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_checksum     <= '0;
            r_checksumOk   <= 1'b0;
`endif
          end
        end
        S_COPY: begin
          r_rdVld  <= 1'b1;
          r_imemWe <= r_rdVld;
          if (r_rdCnt < L_WORDS) begin
            r_biosAddr <= r_rdCnt;
            r_rdCnt    <= r_rdCnt + L_ONE;
          end
          // r_rdVld marks that bios_data now holds the word addressed one edge earlier.
          if (r_rdVld) begin
            r_imemWdata <= bus.bios_data;
            r_imemAddr  <= IMEM_BASE + r_wrCnt;
            r_wrCnt     <= r_wrCnt + L_ONE;
`ifdef BOOT_CHECKSUM_EN
            r_checksum  <= r_checksum + bus.bios_data;
`endif
            if (r_wrCnt == L_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_imemWe <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
`ifdef BOOT_CHECKSUM_EN
          r_checksumOk   <= (r_checksum == EXPECTED_SUM);
          r_changeSource <= (r_checksum == EXPECTED_SUM);
`else
          r_changeSource <= 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bios_addr    = r_biosAddr;
  assign bus.imem_we      = r_imemWe;
  assign bus.imem_addr    = r_imemAddr;
  assign bus.imem_wdata   = r_imemWdata;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.changeSource = r_changeSource;
`ifdef BOOT_CHECKSUM_EN
  assign bus.checksum     = r_checksum;
  assign bus.checksum_ok  = r_checksumOk;
`endif

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Copy engine between the BIOS ROM and instruction memory.
- After reset and `start`, it streams BIOS_WORDS consecutive words out of the BIOS ROM and writes them into instruction memory starting at IMEM_BASE.
- It then raises `changeSource` so the fetch mux switches from BIOS to instruction memory.
- It drives the BIOS address bus directly and consumes the BIOS registered data output, which has 1-cycle read latency.

Parameters:
- DATA_WIDTH, 32, width of the BIOS word, the instruction-memory word and the address buses.
- BIOS_WORDS, 41, number of words copied. Legal range 1..2^DATA_WIDTH-1.
- IMEM_BASE, 0, instruction-memory word address that receives BIOS word 0.

Ports:
- clock, input, 1, system clock. All state updates on the rising edge. The BIOS ROM is clocked by the same edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, level-sampled copy request.
- bios_addr, output, DATA_WIDTH, word address to the BIOS ROM.
- bios_data, input, DATA_WIDTH, BIOS read data, valid the cycle after the address is sampled.
- imem_we, output, 1, instruction-memory write enable, one-cycle pulse per word.
- imem_addr, output, DATA_WIDTH, instruction-memory write address.
- imem_wdata, output, DATA_WIDTH, instruction-memory write data.
- busy, output, 1, high while in COPY or DRAIN.
- done, output, 1, high in DONE.
- changeSource, output, 1, fetch-source select: 0 = BIOS, 1 = instruction memory.

Behaviour:
- All outputs are registered. Reset values: bios_addr=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, changeSource=0, state=IDLE.
- rst has priority over every other input. A reset in the middle of a copy aborts on that edge. No further writes are issued, and memory contents already written are left as is.
- Internal state: rd_cnt (next address to issue), rd_vld (an address was issued last cycle), wr_cnt (word index being written).

States:
- IDLE:
  - start=1 -> COPY, with bios_addr<=0, rd_cnt<=1, busy<=1.
  - Otherwise stay.
- COPY:
  - Each edge: rd_vld<=1.
  - If rd_cnt<BIOS_WORDS: bios_addr<=rd_cnt and rd_cnt++. Otherwise bios_addr holds.
  - If rd_vld=1: imem_we<=1, imem_wdata<=bios_data, imem_addr<=IMEM_BASE+wr_cnt, wr_cnt++.
  - When the write of index BIOS_WORDS-1 is being registered -> DRAIN.
- DRAIN (1 cycle): imem_we<=0, busy<=0, done<=1, changeSource<=1 -> DONE.
- DONE:
  - Outputs hold. changeSource stays 1.
  - start=1 restarts the copy: as from IDLE, and additionally done<=0, changeSource<=0.
- start is ignored while busy=1.

Timing (start sampled at edge E0):
- bios_addr=k after E(k), for k<BIOS_WORDS.
- Write of word k is visible (imem_we=1) after E(k+2).
- imem_we is continuous from E2 through E(BIOS_WORDS+1).
- done and changeSource rise after E(BIOS_WORDS+2).
- Total: exactly BIOS_WORDS+2 cycles from the start edge to done.

Arithmetic and boundaries:
- imem_addr addition is modulo 2^DATA_WIDTH and wraps silently.
- BIOS_WORDS=1: one write pulse after E2, done after E3.
- bios_addr never exceeds BIOS_WORDS-1.
- The write of the last word and the DRAIN transition never overlap. DRAIN always follows the last write by one cycle.

Optional Feature:
BOOT_CHECKSUM_EN:
- When defined, the block adds:
  - output `checksum` (DATA_WIDTH): running modulo-2^DATA_WIDTH sum of every word written.
  - output `checksum_ok`.
  - parameter EXPECTED_SUM (default 0).
- checksum behaviour:
  - Cleared on rst and on every copy start.
  - Updated on the same edge that registers each write.
  - Final once done=1.
- checksum_ok=1 only in DONE with checksum==EXPECTED_SUM.
- A mismatch holds changeSource at 0 in DONE, so fetch stays on BIOS.
- When undefined: no such ports, and changeSource behaves as described above.

Test Plan:
- Reset then start pulse, BIOS model with mem[k]=k+0x100, BIOS_WORDS=41 -> 41 writes with imem_addr 0..40 and data 0x100..0x128, contiguous imem_we. done and changeSource rise exactly 43 cycles after the start edge.
- IMEM_BASE=0x200, BIOS_WORDS=1 -> a single write at 0x200 after E2, done after E3, bios_addr stays 0.
- rst asserted 10 cycles into a copy -> next edge: all outputs 0, state IDLE, no further imem_we. A new start then performs a full copy from word 0.
- start held high throughout the copy, and start pulsed again in DONE -> no restart while busy. The pulse in DONE clears done and changeSource and repeats the copy identically.
- IMEM_BASE=0xFFFFFFFE, BIOS_WORDS=4 -> imem_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
- BOOT_CHECKSUM_EN, words 1..41, EXPECTED_SUM=861 -> checksum=861, checksum_ok=1, changeSource=1. With EXPECTED_SUM=0: checksum_ok=0, changeSource=0.
